// File: rtl/moving_average_ctrl_pkg.sv
// Shared settings for the moving-average controller: widths, default
// pipeline latency, controller state encoding and the window legality check.
package package_settings;

    // Width of the averaged samples handled by the datapath.
    localparam int SIZE_DATA        = 16;
    // Width of the window-length bus; must hold SIZE_MAX_WINDOW.
    localparam int SIZE_WINDOW      = 7;
    // Largest supported window length.
    localparam int SIZE_MAX_WINDOW  = 64;
    // Datapath latency from a window change to the first coherent average.
    localparam int PIPE_LAT_DEFAULT = 5;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FILL  = 2'd2,
        ST_RUN   = 2'd3
    } ma_state_t;

    // A window is legal only if it is one of the power-of-two lengths the
    // datapath's shift-based divider supports.
    function automatic logic is_valid_window(input logic [SIZE_WINDOW-1:0] window);
        logic ok;
        ok = 1'b0;
        case (window)
            7'd1, 7'd2, 7'd4, 7'd8, 7'd16, 7'd32, 7'd64: ok = 1'b1;
            default:                                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ma_fill_counter.sv
// Down-counter that times the FILL phase of the moving-average controller.
// A load takes priority over a decrement; the count never wraps below zero.
module ma_fill_counter
    import package_settings::*;
#(
    parameter int SIZE_CNT = $clog2(SIZE_MAX_WINDOW + PIPE_LAT_DEFAULT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [SIZE_CNT-1:0] value,
    input  logic                dec,
    output logic                zero
);

    logic [SIZE_CNT-1:0] r_count;

    // Count register: load the FILL length, then step down toward zero.
    // NOTE: state updates use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/moving_average_ctrl.sv
// Moving-average controller: accepts window-change requests, clears the
// averaging datapath, waits for it to refill and then flags valid output.
// Optional build macro MA_CTRL_AUTOSTART_EN: when defined, the first cycle
// after reset release loads DEFAULT_WINDOW and starts a flush on its own.
module moving_average_ctrl
    import package_settings::*;
#(
    parameter int PIPE_LAT       = PIPE_LAT_DEFAULT,
    parameter int DEFAULT_WINDOW = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_valid,
    input  logic [SIZE_WINDOW-1:0] cfg_window,
    output logic                   cfg_ready,
    output logic                   cfg_err,
    output logic                   ma_rst_n,
    output logic [SIZE_WINDOW-1:0] ma_window,
    output logic                   ma_enable,
    output logic                   out_valid,
    output logic                   busy
);

    // Fill counter must reach SIZE_MAX_WINDOW + PIPE_LAT - 1 without wrapping.
    localparam int SIZE_FILL = $clog2(SIZE_MAX_WINDOW + PIPE_LAT);

    ma_state_t              r_state;
    logic                   r_armed;
    logic                   r_cfg_err;
    logic                   r_ma_rst_n;
    logic [SIZE_WINDOW-1:0] r_ma_window;
    logic                   r_ma_enable;
    logic                   r_out_valid;
    logic                   r_busy;

    logic                   w_handshake;
    logic                   w_window_ok;
    logic                   w_fill_load;
    logic                   w_fill_dec;
    logic                   w_fill_zero;
    logic [SIZE_FILL-1:0]   w_fill_value;

    // NOTE: cfg_ready is the one combinational output; r_armed keeps it low
    // until the first clock after reset release so no request can race the
    // controller's own start-up (including the autostart flush).
    assign cfg_ready   = r_armed && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign w_handshake = cfg_valid && cfg_ready;
    assign w_window_ok = is_valid_window(cfg_window);

    // FILL spans window + PIPE_LAT cycles, so the counter starts one below.
    assign w_fill_value = SIZE_FILL'(r_ma_window) + SIZE_FILL'(PIPE_LAT - 1);
    assign w_fill_load  = (r_state == ST_FLUSH);
    assign w_fill_dec   = (r_state == ST_FILL) && !w_fill_zero;

    ma_fill_counter #(
        .SIZE_CNT (SIZE_FILL)
    ) u_fill_counter (
        .clk   (clk),
        .reset (reset),
        .load  (w_fill_load),
        .value (w_fill_value),
        .dec   (w_fill_dec),
        .zero  (w_fill_zero)
    );

    // Controller FSM with every datapath-facing output registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_armed     <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_ma_rst_n  <= 1'b0;
            r_ma_window <= '0;
            r_ma_enable <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Rejection flag is a single-cycle pulse unless re-raised below.
            r_cfg_err <= 1'b0;

            if (!r_armed) begin
                // First cycle after reset release.
                r_armed <= 1'b1;
`ifdef MA_CTRL_AUTOSTART_EN
                r_ma_window <= SIZE_WINDOW'(DEFAULT_WINDOW);
                r_state     <= ST_FLUSH;
                r_ma_rst_n  <= 1'b0;
                r_busy      <= 1'b1;
`else
                r_ma_rst_n  <= 1'b1;
`endif
            end else begin
                case (r_state)
                    ST_IDLE, ST_RUN: begin
                        if (w_handshake) begin
                            if (w_window_ok) begin
                                // Any accepted request, even the same window,
                                // restarts the clear-and-refill sequence.
                                r_ma_window <= cfg_window;
                                r_state     <= ST_FLUSH;
                                r_ma_rst_n  <= 1'b0;
                                r_busy      <= 1'b1;
                                r_ma_enable <= 1'b0;
                                r_out_valid <= 1'b0;
                            end else begin
                                // Rejected: report it and keep running as before.
                                r_cfg_err <= 1'b1;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        r_state    <= ST_FILL;
                        r_ma_rst_n <= 1'b1;
                    end
                    ST_FILL: begin
                        if (w_fill_zero) begin
                            r_state     <= ST_RUN;
                            r_busy      <= 1'b0;
                            r_ma_enable <= 1'b1;
                            r_out_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg_err   = r_cfg_err;
    assign ma_rst_n  = r_ma_rst_n;
    assign ma_window = r_ma_window;
    assign ma_enable = r_ma_enable;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_moving_average_ctrl.sv
// Self-checking bench for moving_average_ctrl. A timeline model tracks how
// many clocks have passed since the last accepted window and derives every
// expected output from that count.
module tb_moving_average_ctrl;
    import package_settings::*;

    localparam int PIPE_LAT       = 5;
    localparam int DEFAULT_WINDOW = 8;

    logic                   clk;
    logic                   reset;
    logic                   cfg_valid;
    logic [SIZE_WINDOW-1:0] cfg_window;
    logic                   cfg_ready;
    logic                   cfg_err;
    logic                   ma_rst_n;
    logic [SIZE_WINDOW-1:0] ma_window;
    logic                   ma_enable;
    logic                   out_valid;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    // Model: armed after the first clock out of reset; active once a window
    // has been accepted; m_k = clocks elapsed since that acceptance.
    bit m_armed;
    bit m_active;
    bit m_err;
    bit m_hs;
    int m_k;
    int m_window;

    moving_average_ctrl #(
        .PIPE_LAT       (PIPE_LAT),
        .DEFAULT_WINDOW (DEFAULT_WINDOW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_window (cfg_window),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .ma_rst_n   (ma_rst_n),
        .ma_window  (ma_window),
        .ma_enable  (ma_enable),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [12:0] got;
    assign got = {cfg_ready, cfg_err, ma_rst_n, ma_window, ma_enable, out_valid, busy};

    function automatic bit is_legal(input int w);
        return w inside {1, 2, 4, 8, 16, 32, 64};
    endfunction

    // After acceptance: one flush cycle (k=0), window+PIPE_LAT fill cycles, then run.
    function automatic bit exp_run();
        return m_active && (m_k > m_window + PIPE_LAT);
    endfunction

    function automatic bit exp_ready();
        return m_armed && (!m_active || exp_run());
    endfunction

    function automatic logic [12:0] exp_vec();
        logic bsy;
        logic rstn;
        logic [6:0] win;
        bsy  = m_active && (m_k <= m_window + PIPE_LAT);
        rstn = m_armed && !(m_active && (m_k == 0));
        win  = 7'(m_window);
        return {exp_ready(), m_err, rstn, win, exp_run(), exp_run(), bsy};
    endfunction

    function automatic string fmt(input logic [12:0] v);
        return $sformatf("rdy=%0b err=%0b rstn=%0b win=%0d en=%0b ov=%0b busy=%0b",
                         v[12], v[11], v[10], v[9:3], v[2], v[1], v[0]);
    endfunction

    task automatic model_reset();
        m_armed  = 1'b0;
        m_active = 1'b0;
        m_err    = 1'b0;
        m_hs     = 1'b0;
        m_k      = 0;
        m_window = 0;
    endtask

    // Advance one clock: the model decides the handshake from its own ready,
    // updates at the edge, and returns at the following falling edge.
    task automatic tick();
        m_hs = cfg_valid && exp_ready();
        @(posedge clk);
        m_err = 1'b0;
        if (!m_armed) begin
            m_armed = 1'b1;
`ifdef MA_CTRL_AUTOSTART_EN
            m_active = 1'b1;
            m_k      = 0;
            m_window = DEFAULT_WINDOW;
`endif
        end else if (m_hs && is_legal(int'(cfg_window))) begin
            m_window = int'(cfg_window);
            m_active = 1'b1;
            m_k      = 0;
        end else begin
            if (m_hs) m_err = 1'b1;
            if (m_active && m_k < 1000) m_k++;
        end
        @(negedge clk);
    endtask

    // Tick until the model says the controller is ready, bounded.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!exp_ready() && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (!exp_ready()) begin
            failures++;
            $display("FAIL %s_ready_timeout waited=%0d limit=200", tag, n);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_window = '0;
        model_reset();
        #1;
        checks++;
        if (got !== 13'd0) begin
            failures++;
            $display("FAIL reset_async got %s exp %s", fmt(got), fmt(13'd0));
        end
        repeat (2) @(negedge clk);
        checks++;
        if (got !== 13'd0) begin
            failures++;
            $display("FAIL reset_held got %s exp %s", fmt(got), fmt(13'd0));
        end
        reset = 1'b1;
        #1;
        checks++;
        if (got !== exp_vec()) begin
            failures++;
            $display("FAIL reset_release got %s exp %s", fmt(got), fmt(exp_vec()));
        end
        tick();
        checks++;
        if (got !== exp_vec()) begin
            failures++;
            $display("FAIL reset_first_cycle got %s exp %s", fmt(got), fmt(exp_vec()));
        end
    endtask

    task automatic test_basic();
        int n_busy;
        int n_rst;
        int first_valid;
        wait_ready("basic");
        cfg_valid  = 1'b1;
        cfg_window = 7'd8;
        tick();
        cfg_valid = 1'b0;
        n_busy = 0;
        n_rst = 0;
        first_valid = 0;
        for (int c = 1; c <= 20; c++) begin
            checks++;
            if (got !== exp_vec()) begin
                failures++;
                $display("FAIL basic c=%0d got %s exp %s", c, fmt(got), fmt(exp_vec()));
            end
            if (busy) n_busy++;
            if (!ma_rst_n) n_rst++;
            if (out_valid && first_valid == 0) first_valid = c;
            tick();
        end
        checks++;
        if (n_busy != 14 || n_rst != 1 || first_valid != 15 || ma_window !== 7'd8) begin
            failures++;
            $display("FAIL basic_timing busy=%0d rst=%0d first_valid=%0d win=%0d exp 14 1 15 8",
                     n_busy, n_rst, first_valid, ma_window);
        end
    endtask

    task automatic test_invalid_in_run();
        int n_err;
        int n_low;
        wait_ready("invalid");
        cfg_valid  = 1'b1;
        cfg_window = 7'd6;
        tick();
        cfg_valid = 1'b0;
        n_err = 0;
        n_low = 0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (got !== exp_vec()) begin
                failures++;
                $display("FAIL invalid c=%0d got %s exp %s", c, fmt(got), fmt(exp_vec()));
            end
            if (cfg_err) n_err++;
            if (!out_valid || ma_window !== 7'd8) n_low++;
            tick();
        end
        checks++;
        if (n_err != 1 || n_low != 0) begin
            failures++;
            $display("FAIL invalid_summary err_pulses=%0d disturbed=%0d exp 1 0", n_err, n_low);
        end
    endtask

    task automatic test_window64();
        int n_fill;
        int n_rst;
        int c;
        wait_ready("win64");
        cfg_valid  = 1'b1;
        cfg_window = 7'd64;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || ma_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL win64_drop ov=%0b rstn=%0b exp 0 0", out_valid, ma_rst_n);
        end
        n_fill = 0;
        n_rst = 0;
        c = 0;
        while (!out_valid && c < 100) begin
            checks++;
            if (got !== exp_vec()) begin
                failures++;
                $display("FAIL win64 c=%0d got %s exp %s", c, fmt(got), fmt(exp_vec()));
            end
            if (busy && ma_rst_n) n_fill++;
            if (!ma_rst_n) n_rst++;
            tick();
            c++;
        end
        checks++;
        if (n_fill != 69 || n_rst != 1 || !out_valid || ma_window !== 7'd64) begin
            failures++;
            $display("FAIL win64_summary fill=%0d rst=%0d ov=%0b win=%0d exp 69 1 1 64",
                     n_fill, n_rst, out_valid, ma_window);
        end
    endtask

    task automatic test_held_request();
        int cnt;
        int n_run;
        int n_ready_fill;
        wait_ready("held");
        cfg_valid  = 1'b1;
        cfg_window = 7'd2;
        tick();
        cnt = 0;
        n_run = 0;
        n_ready_fill = 0;
        m_hs = 1'b0;
        while (!m_hs && cnt < 40) begin
            checks++;
            if (got !== exp_vec()) begin
                failures++;
                $display("FAIL held c=%0d got %s exp %s", cnt, fmt(got), fmt(exp_vec()));
            end
            if (out_valid) n_run++;
            if (busy && cfg_ready) n_ready_fill++;
            tick();
            cnt++;
        end
        cfg_valid = 1'b0;
        checks++;
        if (cnt != 9 || n_run != 1 || n_ready_fill != 0) begin
            failures++;
            $display("FAIL held_summary accept_after=%0d run_cycles=%0d ready_in_fill=%0d exp 9 1 0",
                     cnt, n_run, n_ready_fill);
        end
        checks++;
        if (got !== exp_vec() || ma_rst_n !== 1'b0 || ma_window !== 7'd2) begin
            failures++;
            $display("FAIL held_restart got %s exp %s", fmt(got), fmt(exp_vec()));
        end
    endtask

    task automatic test_window1();
        int n_fill;
        int c;
        wait_ready("win1");
        cfg_valid  = 1'b1;
        cfg_window = 7'd1;
        tick();
        cfg_valid = 1'b0;
        n_fill = 0;
        c = 0;
        while (!ma_enable && c < 30) begin
            checks++;
            if (got !== exp_vec()) begin
                failures++;
                $display("FAIL win1 c=%0d got %s exp %s", c, fmt(got), fmt(exp_vec()));
            end
            if (busy && ma_rst_n) n_fill++;
            tick();
            c++;
        end
        checks++;
        if (n_fill != 6 || ma_enable !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL win1_summary fill=%0d en=%0b ov=%0b exp 6 1 1", n_fill, ma_enable, out_valid);
        end
    endtask

    task automatic test_reset_mid_fill();
        wait_ready("midfill");
        cfg_valid  = 1'b1;
        cfg_window = 7'd16;
        tick();
        cfg_window = 7'd4;
        repeat (3) tick();
        checks++;
        if (got !== exp_vec() || !busy || !ma_rst_n) begin
            failures++;
            $display("FAIL midfill_pre got %s exp %s", fmt(got), fmt(exp_vec()));
        end
        #2;
        reset     = 1'b0;
        cfg_valid = 1'b0;
        model_reset();
        #1;
        checks++;
        if (got !== 13'd0) begin
            failures++;
            $display("FAIL midfill_abort got %s exp %s", fmt(got), fmt(13'd0));
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (got !== exp_vec()) begin
                failures++;
                $display("FAIL midfill_after c=%0d got %s exp %s", c, fmt(got), fmt(exp_vec()));
            end
        end
`ifdef MA_CTRL_AUTOSTART_EN
        checks++;
        if (ma_window !== 7'd8) begin
            failures++;
            $display("FAIL midfill_window got %0d exp 8", ma_window);
        end
`else
        checks++;
        if (ma_window !== 7'd0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL midfill_idle win=%0d busy=%0b rdy=%0b exp 0 0 1", ma_window, busy, cfg_ready);
        end
`endif
    endtask

    task automatic test_random();
        int lens [7] = '{1, 2, 4, 8, 16, 32, 64};
        for (int c = 0; c < 1500; c++) begin
            cfg_valid = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) < 7) cfg_window = 7'(lens[$urandom_range(0, 6)]);
            else                          cfg_window = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 299) == 0) begin
                #2;
                reset = 1'b0;
                model_reset();
                #1;
                checks++;
                if (got !== 13'd0) begin
                    failures++;
                    $display("FAIL random_reset c=%0d got %s", c, fmt(got));
                end
                @(negedge clk);
                reset = 1'b1;
            end
            tick();
            checks++;
            if (got !== exp_vec()) begin
                failures++;
                $display("FAIL random c=%0d got %s exp %s", c, fmt(got), fmt(exp_vec()));
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid_in_run();
        test_window64();
        test_held_request();
        test_window1();
        test_reset_mid_fill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
